axi_sram_slave: RTL
===================

Name: axi_sram_slave

Overview:
- AXI4 slave responder that terminates one slave port of the interconnect (S0/S1 side) and drives a single-port synchronous SRAM macro.
- Accepts one read or one write burst at a time over the AR/R and AW/W/B channels.
- Sequences per-beat SRAM accesses and returns R data or a B response tagged with the 8-bit slave-side ID.

Parameters:
- SRAM_AW, 14, SRAM word-address width. Word index = AxADDR[SRAM_AW+1:2].
- ID_W, 8, slave-side ID width (`AXI_IDS_BITS).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- AWID  in  ID_W  write burst ID
- AWADDR  in  32  write byte address
- AWLEN  in  4  beats-1
- AWSIZE  in  3  ignored, 32-bit assumed
- AWBURST  in  2  ignored, INCR always
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  32  write data
- WSTRB  in  4  byte strobes
- WLAST  in  1  last write beat
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BID  out  ID_W  response ID
- BRESP  out  2  write response
- BVALID  out  1  response valid
- BREADY  in  1  response ready
- ARID  in  ID_W  read burst ID
- ARADDR  in  32  read byte address
- ARLEN  in  4  beats-1
- ARSIZE  in  3  ignored
- ARBURST  in  2  ignored
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RID  out  ID_W  read data ID
- RDATA  out  32  read data
- RRESP  out  2  read response
- RLAST  out  1  last read beat
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- CEB  out  1  SRAM chip enable, active-low
- WEB  out  1  SRAM write enable, active-low
- BWEB  out  32  SRAM bit write enable, active-low
- A  out  SRAM_AW  SRAM word address
- DI  out  32  SRAM write data
- DO  in  32  SRAM read data. Valid 1 cycle after enabled read; held while CEB=1.

Behaviour:
- FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP.
- Registered burst context: id, addr (SRAM_AW bits), len, beat counter (4 bits), err flag.
- Reset:
  - State = IDLE.
  - AWREADY = ARREADY = WREADY = BVALID = RVALID = RLAST = 0.
  - BRESP = RRESP = 2'b00; BID = RID = 0; RDATA = 0.
  - CEB = WEB = 1; BWEB = all 1s.
  - Reset mid-burst abandons the burst immediately; no SRAM access in the reset cycle.
- IDLE:
  - AWREADY = ARREADY = 1 (combinational from state).
  - AWVALID has priority: if AWVALID, latch AW fields, counter = 0, err = 0, go to WR_DATA.
  - Else if ARVALID, latch AR fields, go to RD_REQ.
  - When both valid, only AWREADY is asserted that cycle; ARREADY = 0.
- RD_REQ:
  - CEB = 0, WEB = 1, A = addr. Next state RD_DATA.
- RD_DATA:
  - RVALID = 1, RDATA = DO, RID = id, RRESP = 2'b00.
  - RLAST = (counter == len).
  - RDATA must stay stable while RREADY = 0; CEB stays 1 so DO holds.
  - On RREADY with RLAST → IDLE.
  - On RREADY without RLAST → addr + 1, counter + 1, go to RD_REQ.
  - Throughput: 1 beat per 2 cycles. AR handshake to first RVALID = 2 cycles.
- WR_DATA:
  - WREADY = 1.
  - On WVALID and counter <= len:
    - CEB = 0, WEB = 0, A = addr, DI = WDATA.
    - BWEB byte k = {8{~WSTRB[k]}}.
    - addr + 1, counter + 1.
  - Beats arriving with counter > len are accepted but not written; err = 1.
  - On a beat with WLAST: err |= (counter != len); go to WR_RESP.
  - CEB = 1 in any cycle without a write handshake.
- WR_RESP:
  - BVALID = 1, BID = id, BRESP = err ? 2'b10 (SLVERR) : 2'b00.
  - On BREADY → IDLE.
- Address arithmetic: addr increments modulo 2^SRAM_AW (0x3FFF + 1 → 0x0000). Upper AxADDR bits are ignored.
- Only one outstanding transaction. No new AW/AR is accepted outside IDLE.

Test Plan:
- Single write then read:
  - Stimulus: AW addr 0x0000_0010, len 0, WDATA 0xDEADBEEF, WSTRB 4'hF.
  - Response: SRAM A = 4, WEB = 0. BVALID with BRESP 00, BID = AWID.
  - Then AR same addr: RVALID 2 cycles after AR handshake, RDATA 0xDEADBEEF, RLAST = 1.
- Read burst with backpressure:
  - Stimulus: ARLEN = 3 at word 8, RREADY low for 3 cycles on beat 1.
  - Response: 4 beats from A = 8..11. RDATA stable while stalled. RLAST only on beat 4.
- Partial strobe:
  - Stimulus: WSTRB 4'b0101 on a single-beat write.
  - Response: BWEB = 0xFF00FF00. Readback shows only bytes 0 and 2 updated.
- Simultaneous AWVALID/ARVALID in IDLE:
  - Response: AWREADY = 1, ARREADY = 0. Write completes, then AR is accepted in the next IDLE cycle.
- Length mismatch:
  - Stimulus: AWLEN = 1, WLAST on beat 0 → BRESP = 2'b10.
  - Stimulus: AWLEN = 0 with 3 beats, WLAST on the third → only beat 0 written, BRESP = 2'b10.
- Wrap and reset:
  - Stimulus: write burst len 1 at word 0x3FFF.
  - Response: second beat lands at A = 0.
  - Stimulus: rst asserted during RD_DATA.
  - Response: next cycle RVALID = 0, CEB = 1, ARREADY = 1.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle between the interconnect slave port and the SRAM responder.
// The slave modport is used by axi_sram_slave; the master modport by whoever drives it.
interface axi_sram_slave_if #(
  parameter int ID_W = 8
) ();

  // Write address channel
  logic [ID_W-1:0] AWID;
  logic [31:0]     AWADDR;
  logic [3:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic            AWVALID;
  logic            AWREADY;

  // Write data channel
  logic [31:0]     WDATA;
  logic [3:0]      WSTRB;
  logic            WLAST;
  logic            WVALID;
  logic            WREADY;

  // Write response channel
  logic [ID_W-1:0] BID;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;

  // Read address channel
  logic [ID_W-1:0] ARID;
  logic [31:0]     ARADDR;
  logic [3:0]      ARLEN;
  logic [2:0]      ARSIZE;
  logic [1:0]      ARBURST;
  logic            ARVALID;
  logic            ARREADY;

  // Read data channel
  logic [ID_W-1:0] RID;
  logic [31:0]     RDATA;
  logic [1:0]      RRESP;
  logic            RLAST;
  logic            RVALID;
  logic            RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave responder in front of a single-port synchronous SRAM macro.
// One burst (read or write) is in flight at a time; each beat becomes one
// SRAM access. Reads take two cycles per beat (request, then data), writes
// go straight through in the W handshake cycle.
module axi_sram_slave #(
  parameter int SRAM_AW = 14,
  parameter int ID_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  axi_sram_slave_if.slave    axi,
  output logic               CEB,
  output logic               WEB,
  output logic [31:0]        BWEB,
  output logic [SRAM_AW-1:0] A,
  output logic [31:0]        DI,
  input  logic [31:0]        DO
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    id;
  logic [SRAM_AW-1:0] addr;
  logic [3:0]         len;
  logic [3:0]         cnt;
  logic               err;
  // Set once the last in-range write beat has gone to the SRAM, so a
  // 16-beat burst cannot wrap the 4-bit counter and write again.
  logic               done;

  logic               wr_fire;
  logic               rd_fire;
  logic               unused_bits;

  // Size/burst are fixed (32-bit INCR) and the upper address bits fall outside the macro.
  assign unused_bits = ^{axi.AWSIZE, axi.AWBURST, axi.ARSIZE, axi.ARBURST,
                         axi.AWADDR[31:SRAM_AW+2], axi.AWADDR[1:0],
                         axi.ARADDR[31:SRAM_AW+2], axi.ARADDR[1:0]};

  // SRAM access qualifiers; nothing reaches the macro while reset is held.
  always_comb begin
    wr_fire = !rst && (state == WR_DATA) && axi.WVALID && !done;
    rd_fire = !rst && (state == RD_REQ);
  end

  // Bus handshakes and SRAM pins decoded from the registered state.
  always_comb begin
    axi.AWREADY = !rst && (state == IDLE);
    axi.ARREADY = !rst && (state == IDLE) && !axi.AWVALID;
    axi.WREADY  = !rst && (state == WR_DATA);

    axi.BVALID  = !rst && (state == WR_RESP);
    axi.BID     = rst ? '0 : id;
    axi.BRESP   = (axi.BVALID && err) ? 2'b10 : 2'b00;

    axi.RVALID  = !rst && (state == RD_DATA);
    axi.RID     = rst ? '0 : id;
    axi.RDATA   = axi.RVALID ? DO : 32'h0;
    axi.RRESP   = 2'b00;
    axi.RLAST   = axi.RVALID && (cnt == len);

    CEB  = !(wr_fire || rd_fire);
    WEB  = !wr_fire;
    A    = addr;
    DI   = axi.WDATA;
    BWEB = '1;
    if (wr_fire) begin
      for (int k = 0; k < 4; k++) begin
        BWEB[8*k +: 8] = {8{~axi.WSTRB[k]}};
      end
    end
  end

  // Burst sequencer: latches the address phase and walks beats until the response is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      id    <= '0;
      addr  <= '0;
      len   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (axi.AWVALID) begin
            id    <= axi.AWID;
            addr  <= axi.AWADDR[SRAM_AW+1:2];
            len   <= axi.AWLEN;
            cnt   <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
            state <= WR_DATA;
          end else if (axi.ARVALID) begin
            id    <= axi.ARID;
            addr  <= axi.ARADDR[SRAM_AW+1:2];
            len   <= axi.ARLEN;
            cnt   <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
            state <= RD_REQ;
          end
        end

        RD_REQ: begin
          state <= RD_DATA;
        end

        RD_DATA: begin
          if (axi.RREADY) begin
            if (cnt == len) begin
              state <= IDLE;
            end else begin
              addr  <= addr + SRAM_AW'(1);
              cnt   <= cnt + 4'd1;
              state <= RD_REQ;
            end
          end
        end

        WR_DATA: begin
          if (axi.WVALID) begin
            if (!done) begin
              addr <= addr + SRAM_AW'(1);
              cnt  <= cnt + 4'd1;
              if (cnt == len) begin
                done <= 1'b1;
              end
            end
            if (axi.WLAST) begin
              err   <= err | done | (cnt != len);
              state <= WR_RESP;
            end else if (done) begin
              err <= 1'b1;
            end
          end
        end

        WR_RESP: begin
          if (axi.BREADY) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
